menu_ctl: RTL and testbench

Frame-synchronous controller for the start-menu overlay and the game-phase sequence. It debounces the three menu buttons and owns the player-count selection that drives the highlighted rows in the character overlay. It issues a one-cycle game start, tracks the running and game-over phases, and returns to the menu after a fixed number of frames. It sits between the button pins and the overlay/game logic, in the pclk domain.

---
 rtl/menu_ctl.sv | 143 ++++++++++++++
 tb/tb_menu_ctl.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/menu_ctl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | menu_ctl                                                                   |
// | Start-menu button debounce, player selection and game-phase sequencing.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module menu_ctl #(
  parameter int DB_CYCLES   = 650000,
  parameter int OVER_FRAMES = 120
) (
  input  logic pclk,
  input  logic rst,
  input  logic btn_up,
  input  logic btn_down,
  input  logic btn_start,
  input  logic vblnk,
  input  logic game_over,
  output logic player_count,
  output logic menu_active,
  output logic game_running,
  output logic game_start
);

  localparam int                 c_CNT_W     = $clog2(DB_CYCLES + 1);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST  = c_CNT_W'(DB_CYCLES - 1);
  localparam logic [7:0]         c_OVER_LAST = 8'(OVER_FRAMES);

  localparam logic [1:0] S_MENU       = 2'd0;
  localparam logic [1:0] S_START_WAIT = 2'd1;
  localparam logic [1:0] S_RUNNING    = 2'd2;
  localparam logic [1:0] S_OVER       = 2'd3;

  logic [2:0] w_btn_raw;
  logic [2:0] w_evt;
  logic       w_vf_tick;
  logic       r_vblnk_d;
  logic       r_pending_sel;
  logic [7:0] r_frame_cnt;
  logic [1:0] r_state;
  logic [1:0] w_state_next;
  logic       w_menu_active_next;
  logic       w_game_running_next;
  logic       w_game_start_next;

  assign w_btn_raw = {btn_start, btn_down, btn_up};

  // Bit 0 = up, bit 1 = down, bit 2 = start; each lane is sync + debounce + rise pulse.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_btn
      logic               r_sync1;
      logic               r_sync2;
      logic               r_db;
      logic               r_db_d;
      logic               r_evt;
      logic [c_CNT_W-1:0] r_cnt;

      always_ff @(posedge pclk) begin
        if (rst) begin
          r_sync1 <= 1'b0;
          r_sync2 <= 1'b0;
          r_db    <= 1'b0;
          r_db_d  <= 1'b0;
          r_evt   <= 1'b0;
          r_cnt   <= '0;
        end else begin
          r_sync1 <= w_btn_raw[gi];
          r_sync2 <= r_sync1;
          r_db_d  <= r_db;
          r_evt   <= r_db & ~r_db_d;
          if (r_sync2 == r_db) begin
            r_cnt <= '0;
          end else if (r_cnt == c_CNT_LAST) begin
            r_db  <= r_sync2;
            r_cnt <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
      end

      assign w_evt[gi] = r_evt;
    end
  endgenerate

  assign w_vf_tick = vblnk & ~r_vblnk_d;

  always_ff @(posedge pclk) begin
    if (rst) begin
      r_vblnk_d     <= 1'b0;
      r_pending_sel <= 1'b0;
      player_count  <= 1'b0;
      r_frame_cnt   <= 8'd0;
    end else begin
      r_vblnk_d <= vblnk;
      // Opposing up/down in the same cycle cancel out.
      if ((r_state == S_MENU) && (w_evt[0] ^ w_evt[1])) begin
        r_pending_sel <= w_evt[1];
      end
      if (w_vf_tick) begin
        player_count <= r_pending_sel;
      end
      if ((r_state == S_RUNNING) && game_over) begin
        r_frame_cnt <= 8'd0;
      end else if ((r_state == S_OVER) && w_vf_tick) begin
        r_frame_cnt <= r_frame_cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      r_state      <= S_MENU;
      menu_active  <= 1'b1;
      game_running <= 1'b0;
      game_start   <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      menu_active  <= w_menu_active_next;
      game_running <= w_game_running_next;
      game_start   <= w_game_start_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_MENU:       if (w_evt[2]) w_state_next = S_START_WAIT;
      S_START_WAIT: if (w_vf_tick) w_state_next = S_RUNNING;
      S_RUNNING:    if (game_over) w_state_next = S_OVER;
      S_OVER:       if (w_vf_tick && ((r_frame_cnt + 8'd1) == c_OVER_LAST)) w_state_next = S_MENU;
      default:      w_state_next = S_MENU;
    endcase
  end

  // Outputs are decoded from the next state so they register alongside it.
  always_comb begin
    w_menu_active_next  = (w_state_next == S_MENU) || (w_state_next == S_START_WAIT);
    w_game_running_next = (w_state_next == S_RUNNING);
    w_game_start_next   = (r_state == S_START_WAIT) && (w_state_next == S_RUNNING);
  end

endmodule
`default_nettype wire

// File: tb/tb_menu_ctl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_menu_ctl                                                                |
// | Scoreboard bench for menu_ctl against a history-based reference model.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_menu_ctl;

  localparam int DB        = 4;
  localparam int OF        = 3;
  localparam int VB_PERIOD = 40;
  localparam int VB_HIGH   = 16;

  logic pclk = 1'b0;
  logic rst = 1'b1;
  logic btn_up = 1'b0;
  logic btn_down = 1'b0;
  logic btn_start = 1'b0;
  logic vblnk = 1'b0;
  logic game_over = 1'b0;
  logic player_count;
  logic menu_active;
  logic game_running;
  logic game_start;

  menu_ctl #(.DB_CYCLES(DB), .OVER_FRAMES(OF)) dut (
    .pclk(pclk),
    .rst(rst),
    .btn_up(btn_up),
    .btn_down(btn_down),
    .btn_start(btn_start),
    .vblnk(vblnk),
    .game_over(game_over),
    .player_count(player_count),
    .menu_active(menu_active),
    .game_running(game_running),
    .game_start(game_start)
  );

  always #5 pclk = ~pclk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int vb_pos = 0;

  typedef struct {
    int         cyc;
    logic [3:0] vec;
  } exp_t;
  exp_t sb_q[$];

  // vblnk changes on the falling edge so it is stable at every rising edge.
  initial begin
    forever begin
      @(negedge pclk);
      vblnk  = (vb_pos >= VB_PERIOD - VB_HIGH);
      vb_pos = (vb_pos + 1) % VB_PERIOD;
    end
  end

  // Reference model: a button's level flips once its 2-cycle-delayed raw
  // history has disagreed with the current level for DB straight samples.
  typedef enum {P_MENU, P_WAIT, P_RUN, P_OVER} phase_t;
  phase_t     m_phase = P_MENU;
  bit         m_hist[3][$];
  bit         m_db[3];
  bit         m_rise[3];
  bit         m_ev[3];
  bit         m_sel;
  bit         m_pc;
  bit         m_vb_prev;
  bit         m_start;
  int         m_frames;
  logic [3:0] m_vec_prev = 4'b0100;

  function automatic void model_reset();
    m_phase   = P_MENU;
    m_sel     = 1'b0;
    m_pc      = 1'b0;
    m_vb_prev = 1'b0;
    m_start   = 1'b0;
    m_frames  = 0;
    for (int b = 0; b < 3; b++) begin
      m_db[b]   = 1'b0;
      m_rise[b] = 1'b0;
      m_ev[b]   = 1'b0;
      m_hist[b].delete();
      for (int j = 0; j < DB + 2; j++) m_hist[b].push_back(1'b0);
    end
  endfunction

  always @(posedge pclk) begin
    bit         raw[3];
    bit         ev[3];
    bit         vf;
    bit         sel_old;
    logic [3:0] v;
    cyc++;
    raw[0] = btn_up;
    raw[1] = btn_down;
    raw[2] = btn_start;
    if (rst) begin
      model_reset();
    end else begin
      ev        = m_ev;
      vf        = vblnk && !m_vb_prev;
      m_vb_prev = vblnk;
      sel_old   = m_sel;
      m_start   = 1'b0;
      case (m_phase)
        P_MENU: begin
          if (ev[0] && !ev[1]) m_sel = 1'b0;
          else if (ev[1] && !ev[0]) m_sel = 1'b1;
          if (ev[2]) m_phase = P_WAIT;
        end
        P_WAIT: if (vf) begin
          m_phase = P_RUN;
          m_start = 1'b1;
        end
        P_RUN: if (game_over) begin
          m_phase  = P_OVER;
          m_frames = 0;
        end
        P_OVER: if (vf) begin
          m_frames++;
          if (m_frames == OF) m_phase = P_MENU;
        end
      endcase
      if (vf) m_pc = sel_old;
      for (int b = 0; b < 3; b++) begin
        bit flip;
        flip    = 1'b1;
        m_ev[b] = m_rise[b];
        for (int j = 0; j < DB; j++)
          if (m_hist[b][m_hist[b].size() - 2 - j] == m_db[b]) flip = 1'b0;
        m_rise[b] = 1'b0;
        if (flip) begin
          m_db[b]   = !m_db[b];
          m_rise[b] = m_db[b];
        end
        m_hist[b].push_back(raw[b]);
        if (m_hist[b].size() > DB + 2) void'(m_hist[b].pop_front());
      end
    end
    v = {m_pc, (m_phase == P_MENU) || (m_phase == P_WAIT), m_phase == P_RUN, m_start};
    if (v !== m_vec_prev) begin
      sb_q.push_back('{cyc, v});
      m_vec_prev = v;
    end
  end

  // Monitor: every change of the DUT output vector consumes one expected change.
  bit         mon_en = 1'b0;
  logic [3:0] mon_prev = 4'b0100;

  always @(negedge pclk) begin
    logic [3:0] d;
    exp_t       e;
    if (mon_en) begin
      d = {player_count, menu_active, game_running, game_start};
      if (d !== mon_prev) begin
        checks++;
        if (sb_q.size() == 0) begin
          failures++;
          $display("FAIL out_change cyc=%0d got=%b expected no change from %b", cyc, d, mon_prev);
        end else begin
          e = sb_q.pop_front();
          if ((e.vec !== d) || (e.cyc != cyc)) begin
            failures++;
            $display("FAIL out_change cyc=%0d got=%b expected=%b at cyc=%0d", cyc, d, e.vec, e.cyc);
          end
        end
        mon_prev = d;
      end
      if ((sb_q.size() > 0) && (sb_q[0].cyc < cyc)) begin
        checks++;
        failures++;
        $display("FAIL missing_change cyc=%0d got=%b expected=%b at cyc=%0d", cyc, d, sb_q[0].vec, sb_q[0].cyc);
        void'(sb_q.pop_front());
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge pclk);
    #1;
  endtask

  task automatic wait_vb(input logic level);
    int k;
    k = 0;
    while ((vblnk !== level) && (k < 200)) begin
      step(1);
      k++;
    end
    if (k >= 200) begin
      checks++;
      failures++;
      $display("FAIL vblnk_wait got=%b required=%b", vblnk, level);
    end
  endtask

  task automatic press(input logic u, input logic dn, input logic s, input int hold);
    btn_up    = u;
    btn_down  = dn;
    btn_start = s;
    step(hold);
    btn_up    = 1'b0;
    btn_down  = 1'b0;
    btn_start = 1'b0;
  endtask

  initial begin
    logic [3:0] d;
    step(4);
    @(negedge pclk);
    d = {player_count, menu_active, game_running, game_start};
    checks++;
    if (d !== 4'b0100) begin
      failures++;
      $display("FAIL reset_state got=%b required=0100", d);
    end
    mon_prev = d;
    mon_en   = 1'b1;
    @(posedge pclk);
    #1;
    rst = 1'b0;

    // Clean down press, then let a frame edge copy it to player_count.
    press(1'b0, 1'b1, 1'b0, 20);
    step(VB_PERIOD + 10);

    // Bouncing up button: every level lasts 3 cycles, below the debounce length.
    for (int i = 0; i < 10; i++) begin
      btn_up = ~btn_up;
      step(3);
    end
    btn_up = 1'b0;
    step(VB_PERIOD);

    // Start pressed while vblnk is already high.
    wait_vb(1'b0);
    wait_vb(1'b1);
    press(1'b0, 1'b0, 1'b1, 12);
    step(VB_PERIOD + 10);

    // Buttons ignored while running, then the OVER countdown.
    press(1'b1, 1'b0, 1'b0, 20);
    step(5);
    game_over = 1'b1;
    step(2);
    game_over = 1'b0;
    step(4 * VB_PERIOD);

    // Select 1 player, then simultaneous up/down, then up/down/start.
    press(1'b1, 1'b0, 1'b0, 15);
    step(VB_PERIOD + 5);
    press(1'b1, 1'b1, 1'b0, 15);
    step(VB_PERIOD + 5);
    press(1'b1, 1'b1, 1'b1, 15);
    step(VB_PERIOD + 10);
    game_over = 1'b1;
    step(1);
    game_over = 1'b0;
    step(4 * VB_PERIOD);

    // Select 2 players, run, and reset in the middle of OVER.
    press(1'b0, 1'b1, 1'b0, 15);
    step(VB_PERIOD + 5);
    press(1'b0, 1'b0, 1'b1, 15);
    step(VB_PERIOD + 10);
    game_over = 1'b1;
    step(1);
    game_over = 1'b0;
    step(VB_PERIOD + 5);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    step(20);

    // Reset in the middle of a debounce, button released with it.
    btn_down = 1'b1;
    step(4);
    rst      = 1'b1;
    btn_down = 1'b0;
    step(1);
    rst = 1'b0;
    step(VB_PERIOD + 10);

    // Randomised activity.
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 7) == 0) btn_up = ~btn_up;
      if ($urandom_range(0, 7) == 0) btn_down = ~btn_down;
      if ($urandom_range(0, 9) == 0) btn_start = ~btn_start;
      game_over = ($urandom_range(0, 15) == 0);
      rst       = ($urandom_range(0, 499) == 0);
      step(1);
    end
    btn_up    = 1'b0;
    btn_down  = 1'b0;
    btn_start = 1'b0;
    game_over = 1'b0;
    rst       = 1'b0;
    step(60);

    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL pending_expected got=%0d outstanding required=0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
